compare_event_tracker: RTL and testbench
========================================

Name: compare_event_tracker

Overview:
Downstream stage of comparator_4bit. Consumes its one-hot relation flags (eq/gt/lt) each valid cycle and debounces them into a committed relation state. Emits single-cycle change/rise/fall event pulses, a saturating count of entries into GT, and a sticky error on illegal flag encodings. Used wherever a noisy magnitude comparison must become a stable threshold event.

Parameters:
DEBOUNCE, 3, consecutive valid samples of a new relation required to commit it (legal range 1..15)
CNT_W, 8, width of gt_count

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
valid  input  1  flags below are sampled this cycle
a_eq_b  input  1  comparator equal flag
a_gt_b  input  1  comparator greater flag
a_lt_b  input  1  comparator less flag
clear  input  1  synchronous clear of state, counters and error
state  output  2  committed relation: 00 UNKNOWN, 01 LT, 10 EQ, 11 GT
change_pulse  output  1  one cycle high when state changes
rise_pulse  output  1  one cycle high on LT/EQ -> GT commit
fall_pulse  output  1  one cycle high on GT -> LT/EQ commit
gt_count  output  CNT_W  number of commits into GT, saturating
err  output  1  sticky: illegal flag encoding seen

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. On assertion, at any time including mid-streak: state=UNKNOWN, candidate=UNKNOWN, streak=0, gt_count=0, err=0, all pulses 0.
- Sample legal when valid=1 and exactly one of {a_eq_b, a_gt_b, a_lt_b} is 1. Map: lt->01, eq->10, gt->11.
- Illegal sample when valid=1 and the flag count is 0, 2 or 3: err<=1 (sticky), streak<=0, candidate<=UNKNOWN, state unchanged.
- valid=0: all internal registers hold. Gaps do not break a streak. Pulses are 0.
- Legal sample equal to state: streak<=0, candidate<=UNKNOWN (noise rejected).
- Legal sample different from state:
  - If sample==candidate: streak<=streak+1.
  - Otherwise: candidate<=sample, streak<=1.
- Commit occurs when the updated streak value equals DEBOUNCE. Then state<=candidate, streak<=0, candidate<=UNKNOWN, and change_pulse=1 on the same edge. Registered latency: new state is visible after the edge that samples the DEBOUNCE-th consecutive sample.
- With DEBOUNCE=1, the first differing legal sample commits.
- rise_pulse=1 with a commit to GT only if the old state is LT or EQ. There is no rise from UNKNOWN.
- fall_pulse=1 with a commit from GT to LT or EQ.
- gt_count increments on every commit into GT, including from UNKNOWN. It saturates at all-ones.
- clear=1 (synchronous) gives the same values as reset on the next edge. It has priority over a simultaneous valid, and that sample is discarded.
- All pulses are registered. They are high exactly one cycle and default to 0 every cycle otherwise.
- state is never driven to UNKNOWN except by reset or clear.

Decomposition:
- Shared package cmp_pkg: relation encoding constants REL_UNKNOWN, REL_LT, REL_EQ, REL_GT (2-bit).
- Natural sub-module: cmp_flag_decode, a combinational block converting the three flags plus valid into rel[1:0], legal and illegal.
- The debounce FSM, counters and pulses stay in compare_event_tracker.
- The bench instantiates comparator_4bit feeding this block, plus direct flag drive for the illegal-encoding cases.

Test Plan:
1. Reset, then 3 valid GT samples -> after 3rd edge state=11, change_pulse=1, rise_pulse=0, gt_count=1. Before that, state=00.
2. From GT, valid samples LT,LT,EQ,LT,LT,LT -> the EQ restarts the streak. Commit after the final LT: state=01, fall_pulse=1 exactly once, change_pulse=1 once.
3. From LT: valid LT-gap-free samples GT, then valid=0 for 5 cycles, then GT,GT -> commit on the 3rd valid GT: state=11, rise_pulse=1, gt_count increments by 1.
4. Flags {eq,gt,lt}=110 with valid=1 mid-streak (2 GT seen) -> err=1 and stays 1. The streak restarts, so 3 further GT samples are needed to commit.
5. clear=1 in the same cycle as the 3rd committing GT sample -> next cycle state=00, gt_count=0, err=0, no pulses.
6. CNT_W=2 build, 5 LT<->GT commit round-trips -> gt_count stops at 3. Then rst_n low asynchronously between edges with streak=2 -> outputs clear immediately, before the next clk edge.

Source files
------------

// File: rtl/cmp_pkg.sv
// Relation encoding shared by the comparator front end
// and the compare event tracker.
package cmp_pkg;

   typedef logic [1:0] rel_t;

   localparam rel_t REL_UNKNOWN = 2'b00;
   localparam rel_t REL_LT      = 2'b01;
   localparam rel_t REL_EQ      = 2'b10;
   localparam rel_t REL_GT      = 2'b11;

   localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/cmp_flag_decode.sv
// Turns the three comparator flags plus valid into a
// relation code and legal/illegal sample strobes.
module cmp_flag_decode
   import cmp_pkg::*;
(
   input  logic valid,
   input  logic a_eq_b,
   input  logic a_gt_b,
   input  logic a_lt_b,
   output rel_t rel,
   output logic legal,
   output logic illegal
);

   logic oneHot;

   always_comb begin
      rel    = REL_UNKNOWN;
      oneHot = 1'b1;
      unique case ({a_eq_b, a_gt_b, a_lt_b})
         3'b100:  rel = REL_EQ;
         3'b010:  rel = REL_GT;
         3'b001:  rel = REL_LT;
         default: oneHot = 1'b0;
      endcase
      legal   = valid & oneHot;
      illegal = valid & ~oneHot;
   end

endmodule

// File: rtl/comparator_4bit.sv
// 4-bit magnitude comparator producing one-hot
// eq/gt/lt relation flags.
module comparator_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       a_eq_b,
   output logic       a_gt_b,
   output logic       a_lt_b
);

   always_comb begin
      a_eq_b = (a == b);
      a_gt_b = (a > b);
      a_lt_b = (a < b);
   end

endmodule

// File: rtl/compare_event_tracker.sv
// Debounces comparator relation flags into a committed
// state with change/rise/fall pulses and a GT entry count.
module compare_event_tracker
   import cmp_pkg::*;
#(
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic             a_eq_b,
   input  logic             a_gt_b,
   input  logic             a_lt_b,
   input  logic             clear,
   output logic [1:0]       state,
   output logic             change_pulse,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] gt_count,
   output logic             err
);

   localparam logic [STREAK_W-1:0] DEB = STREAK_W'(DEBOUNCE);

   rel_t                rel;
   rel_t                cand;
   logic                legal;
   logic                illegal;
   logic [STREAK_W-1:0] streak;
   logic [STREAK_W-1:0] nextStreak;
   logic                differs;
   logic                commit;

   cmp_flag_decode uDecode (
      .valid   (valid),
      .a_eq_b  (a_eq_b),
      .a_gt_b  (a_gt_b),
      .a_lt_b  (a_lt_b),
      .rel     (rel),
      .legal   (legal),
      .illegal (illegal)
   );

   // A sample matching the pending candidate extends the
   // streak; any other differing sample starts a new one.
   always_comb begin
      differs    = legal && (rel != state);
      nextStreak = (rel == cand) ? streak + 1'b1 : 1'b1;
      commit     = differs && (nextStreak == DEB);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= REL_UNKNOWN;
         cand         <= REL_UNKNOWN;
         streak       <= '0;
         gt_count     <= '0;
         err          <= 1'b0;
         change_pulse <= 1'b0;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
      end else begin
         change_pulse <= 1'b0;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
         if (clear) begin
            state    <= REL_UNKNOWN;
            cand     <= REL_UNKNOWN;
            streak   <= '0;
            gt_count <= '0;
            err      <= 1'b0;
         end else if (illegal) begin
            err    <= 1'b1;
            cand   <= REL_UNKNOWN;
            streak <= '0;
         end else if (legal && !differs) begin
            cand   <= REL_UNKNOWN;
            streak <= '0;
         end else if (commit) begin
            state        <= rel;
            cand         <= REL_UNKNOWN;
            streak       <= '0;
            change_pulse <= 1'b1;
            rise_pulse   <= (rel == REL_GT) &&
                            ((state == REL_LT) ||
                             (state == REL_EQ));
            fall_pulse   <= (state == REL_GT);
            if ((rel == REL_GT) && !(&gt_count))
               gt_count <= gt_count + 1'b1;
         end else if (differs) begin
            cand   <= rel;
            streak <= nextStreak;
         end
      end
   end

endmodule

// File: tb/tb_compare_event_tracker.sv
// Randomized self-checking bench for compare_event_tracker
// against a behavioural relation-debounce model.
module tb_compare_event_tracker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0;
   logic       clear = 1'b0;
   logic       useCmp = 1'b1;
   logic [3:0] opA = 4'd0;
   logic [3:0] opB = 4'd0;
   logic [2:0] dFlg = 3'b000;
   logic       cEq, cGt, cLt;
   logic       fEq, fGt, fLt;

   logic [1:0] st [3];
   logic       chg [3];
   logic       rise [3];
   logic       fall [3];
   logic       er [3];
   logic [7:0] cnt0;
   logic [1:0] cnt1;
   logic [7:0] cnt2;
   logic [13:0] obs [3];

   int total = 0;
   int bad = 0;

   // model state per instance: {DEB=3,W=8}, {DEB=3,W=2}, {DEB=1,W=8}
   int deb [3] = '{3, 3, 1};
   int satv [3] = '{255, 3, 255};
   int mState [3];
   int mCand [3];
   int mStreak [3];
   int mCnt [3];
   bit mErr [3];
   bit mChg [3];
   bit mRise [3];
   bit mFall [3];

   always #5 clk = ~clk;

   comparator_4bit uCmp (
      .a(opA), .b(opB),
      .a_eq_b(cEq), .a_gt_b(cGt), .a_lt_b(cLt)
   );

   assign fEq = useCmp ? cEq : dFlg[2];
   assign fGt = useCmp ? cGt : dFlg[1];
   assign fLt = useCmp ? cLt : dFlg[0];

   compare_event_tracker #(.DEBOUNCE(3), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .valid(valid),
      .a_eq_b(fEq), .a_gt_b(fGt), .a_lt_b(fLt),
      .clear(clear), .state(st[0]),
      .change_pulse(chg[0]), .rise_pulse(rise[0]),
      .fall_pulse(fall[0]), .gt_count(cnt0), .err(er[0])
   );

   compare_event_tracker #(.DEBOUNCE(3), .CNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .valid(valid),
      .a_eq_b(fEq), .a_gt_b(fGt), .a_lt_b(fLt),
      .clear(clear), .state(st[1]),
      .change_pulse(chg[1]), .rise_pulse(rise[1]),
      .fall_pulse(fall[1]), .gt_count(cnt1), .err(er[1])
   );

   compare_event_tracker #(.DEBOUNCE(1), .CNT_W(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .valid(valid),
      .a_eq_b(fEq), .a_gt_b(fGt), .a_lt_b(fLt),
      .clear(clear), .state(st[2]),
      .change_pulse(chg[2]), .rise_pulse(rise[2]),
      .fall_pulse(fall[2]), .gt_count(cnt2), .err(er[2])
   );

   assign obs[0] = {st[0], chg[0], rise[0], fall[0], er[0], cnt0};
   assign obs[1] = {st[1], chg[1], rise[1], fall[1], er[1], 6'd0, cnt1};
   assign obs[2] = {st[2], chg[2], rise[2], fall[2], er[2], cnt2};

   function automatic logic [13:0] expOf(int i);
      return {2'(mState[i]), mChg[i], mRise[i], mFall[i],
              mErr[i], 8'(mCnt[i])};
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         mState[i] = 0; mCand[i] = 0; mStreak[i] = 0;
         mCnt[i] = 0; mErr[i] = 0;
         mChg[i] = 0; mRise[i] = 0; mFall[i] = 0;
      end
   endtask

   // Relation codes: 0 unknown, 1 LT, 2 EQ, 3 GT
   task automatic modelEdge(bit v, bit clr, logic [2:0] flg);
      int ones, r;
      ones = int'(flg[0]) + int'(flg[1]) + int'(flg[2]);
      r = flg[1] ? 3 : (flg[2] ? 2 : 1);
      for (int i = 0; i < 3; i++) begin
         mChg[i] = 0; mRise[i] = 0; mFall[i] = 0;
         if (clr) begin
            mState[i] = 0; mCand[i] = 0; mStreak[i] = 0;
            mCnt[i] = 0; mErr[i] = 0;
         end else if (v && ones != 1) begin
            mErr[i] = 1; mStreak[i] = 0; mCand[i] = 0;
         end else if (v && r == mState[i]) begin
            mStreak[i] = 0; mCand[i] = 0;
         end else if (v) begin
            mStreak[i] = (r == mCand[i]) ? mStreak[i] + 1 : 1;
            mCand[i] = r;
            if (mStreak[i] == deb[i]) begin
               mChg[i] = 1;
               mRise[i] = (r == 3) && (mState[i] == 1 || mState[i] == 2);
               mFall[i] = (mState[i] == 3);
               if (r == 3 && mCnt[i] < satv[i]) mCnt[i]++;
               mState[i] = r; mStreak[i] = 0; mCand[i] = 0;
            end
         end
      end
   endtask

   // Drive one cycle; one-hot flags go through the comparator
   task automatic drv(bit v, bit clr, logic [2:0] flg);
      valid = v;
      clear = clr;
      dFlg = flg;
      useCmp = (flg == 3'b100 || flg == 3'b010 || flg == 3'b001);
      if (flg == 3'b010) begin
         opA = 4'($urandom_range(15, 1));
         opB = 4'($urandom_range(int'(opA) - 1, 0));
      end else if (flg == 3'b001) begin
         opB = 4'($urandom_range(15, 1));
         opA = 4'($urandom_range(int'(opB) - 1, 0));
      end else begin
         opA = 4'($urandom_range(15, 0));
         opB = opA;
      end
      @(posedge clk);
      modelEdge(v, clr, flg);
      #1;
      valid = 1'b0;
      clear = 1'b0;
   endtask

   localparam logic [2:0] GT = 3'b010;
   localparam logic [2:0] LT = 3'b001;
   localparam logic [2:0] EQ = 3'b100;

   task automatic test_reset();
      rst_n = 1'b0;
      modelReset();
      #12;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs[i] !== 14'd0) begin
            bad++;
            $display("FAIL reset inst%0d got=%h want=0", i, obs[i]);
         end
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_gt_commit();
      for (int k = 0; k < 3; k++) begin
         drv(1'b1, 1'b0, GT);
         for (int i = 0; i < 3; i++) begin
            total++;
            if (obs[i] !== expOf(i)) begin
               bad++;
               $display("FAIL gt_commit inst%0d step%0d got=%h want=%h",
                        i, k, obs[i], expOf(i));
            end
         end
         if (k < 2) begin
            total++;
            if (st[0] !== 2'b00) begin
               bad++;
               $display("FAIL gt_early step%0d state=%b want=00", k, st[0]);
            end
         end
      end
      total++;
      if (st[0] !== 2'b11 || chg[0] !== 1'b1 || rise[0] !== 1'b0 ||
          cnt0 !== 8'd1) begin
         bad++;
         $display("FAIL gt_first st=%b chg=%b rise=%b cnt=%0d want 11/1/0/1",
                  st[0], chg[0], rise[0], cnt0);
      end
   endtask

   task automatic test_fall();
      logic [2:0] seq [6] = '{LT, LT, EQ, LT, LT, LT};
      int nFall = 0, nChg = 0;
      for (int k = 0; k < 6; k++) begin
         drv(1'b1, 1'b0, seq[k]);
         nFall += int'(fall[0]);
         nChg += int'(chg[0]);
         for (int i = 0; i < 3; i++) begin
            total++;
            if (obs[i] !== expOf(i)) begin
               bad++;
               $display("FAIL fall inst%0d step%0d got=%h want=%h",
                        i, k, obs[i], expOf(i));
            end
         end
      end
      total++;
      if (st[0] !== 2'b01 || nFall != 1 || nChg != 1) begin
         bad++;
         $display("FAIL fall_once st=%b falls=%0d chgs=%0d want 01/1/1",
                  st[0], nFall, nChg);
      end
   endtask

   task automatic test_gap();
      drv(1'b1, 1'b0, GT);
      for (int k = 0; k < 5; k++) drv(1'b0, 1'b0, GT);
      drv(1'b1, 1'b0, GT);
      total++;
      if (st[0] !== 2'b01 || chg[0] !== 1'b0) begin
         bad++;
         $display("FAIL gap_hold st=%b chg=%b want 01/0", st[0], chg[0]);
      end
      drv(1'b1, 1'b0, GT);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs[i] !== expOf(i)) begin
            bad++;
            $display("FAIL gap inst%0d got=%h want=%h", i, obs[i], expOf(i));
         end
      end
      total++;
      if (st[0] !== 2'b11 || rise[0] !== 1'b1 || cnt0 !== 8'd2) begin
         bad++;
         $display("FAIL gap_rise st=%b rise=%b cnt=%0d want 11/1/2",
                  st[0], rise[0], cnt0);
      end
   endtask

   task automatic test_illegal();
      for (int k = 0; k < 3; k++) drv(1'b1, 1'b0, LT);
      drv(1'b1, 1'b0, GT);
      drv(1'b1, 1'b0, GT);
      drv(1'b1, 1'b0, 3'b110);
      drv(1'b1, 1'b0, GT);
      drv(1'b1, 1'b0, GT);
      total++;
      if (st[0] !== 2'b01 || er[0] !== 1'b1) begin
         bad++;
         $display("FAIL illegal_restart st=%b err=%b want 01/1", st[0], er[0]);
      end
      drv(1'b1, 1'b0, GT);
      drv(1'b1, 1'b0, 3'b000);
      drv(1'b1, 1'b0, 3'b111);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs[i] !== expOf(i)) begin
            bad++;
            $display("FAIL illegal inst%0d got=%h want=%h",
                     i, obs[i], expOf(i));
         end
      end
      total++;
      if (st[0] !== 2'b11 || er[0] !== 1'b1) begin
         bad++;
         $display("FAIL illegal_sticky st=%b err=%b want 11/1", st[0], er[0]);
      end
   endtask

   task automatic test_clear();
      for (int k = 0; k < 3; k++) drv(1'b1, 1'b0, LT);
      drv(1'b1, 1'b0, GT);
      drv(1'b1, 1'b0, GT);
      drv(1'b1, 1'b1, GT);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs[i] !== 14'd0 || obs[i] !== expOf(i)) begin
            bad++;
            $display("FAIL clear inst%0d got=%h want=0", i, obs[i]);
         end
      end
      drv(1'b0, 1'b0, GT);
      total++;
      if (obs[0] !== 14'd0) begin
         bad++;
         $display("FAIL clear_hold got=%h want=0", obs[0]);
      end
   endtask

   task automatic test_saturate();
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 3; k++) drv(1'b1, 1'b0, LT);
         for (int k = 0; k < 3; k++) drv(1'b1, 1'b0, GT);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs[i] !== expOf(i)) begin
            bad++;
            $display("FAIL saturate inst%0d got=%h want=%h",
                     i, obs[i], expOf(i));
         end
      end
      total++;
      if (cnt1 !== 2'd3 || cnt0 !== 8'd5) begin
         bad++;
         $display("FAIL sat_count narrow=%0d wide=%0d want 3/5", cnt1, cnt0);
      end
   endtask

   task automatic test_random();
      logic [2:0] cur = GT;
      logic [2:0] f;
      int r;
      for (int k = 0; k < 600; k++) begin
         r = $urandom_range(99);
         if (r < 20) begin
            case ($urandom_range(2))
               0: cur = LT;
               1: cur = EQ;
               default: cur = GT;
            endcase
         end
         f = ($urandom_range(99) < 4) ? 3'($urandom_range(7)) : cur;
         drv($urandom_range(99) < 80, $urandom_range(199) == 0, f);
         for (int i = 0; i < 3; i++) begin
            total++;
            if (obs[i] !== expOf(i)) begin
               bad++;
               $display("FAIL random inst%0d step%0d got=%h want=%h",
                        i, k, obs[i], expOf(i));
            end
         end
      end
   endtask

   task automatic test_async_reset();
      drv(1'b1, 1'b1, GT);
      for (int k = 0; k < 3; k++) drv(1'b1, 1'b0, LT);
      drv(1'b1, 1'b0, GT);
      drv(1'b1, 1'b0, GT);
      total++;
      if (obs[0] !== expOf(0) || st[0] !== 2'b01) begin
         bad++;
         $display("FAIL pre_async got=%h want=%h", obs[0], expOf(0));
      end
      #3;
      rst_n = 1'b0;
      modelReset();
      #1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs[i] !== 14'd0) begin
            bad++;
            $display("FAIL async_reset inst%0d got=%h want=0", i, obs[i]);
         end
      end
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      drv(1'b1, 1'b0, GT);
      drv(1'b1, 1'b0, GT);
      total++;
      if (st[0] !== 2'b00 || obs[0] !== expOf(0)) begin
         bad++;
         $display("FAIL async_streak got=%h want=%h", obs[0], expOf(0));
      end
   endtask

   initial begin
      modelReset();
      test_reset();
      test_gt_commit();
      test_fall();
      test_gap();
      test_illegal();
      test_clear();
      test_saturate();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
